ecc_sed_decoder: RTL and testbench

- Receive side of the single-error-detect (SED) parity path.
- Accepts 13-bit codewords of the form {parity, data[11:0]} and checks even parity over all 13 bits.
- Forwards the data with a per-word error flag through one registered stage with valid/ready backpressure.
- Keeps a sticky error flag and a saturating error counter for status/CSR readout.

---
 rtl/ecc_sed_pkg.sv | 16 +
 rtl/ecc_sed_err_stats.sv | 43 ++++
 rtl/ecc_sed_decoder.sv | 97 +++++++++
 tb/tb_ecc_sed_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the single-error-detect parity path (encoder and decoder side).
package ecc_sed_pkg;

    localparam int unsigned ECC_DATA_W = 12;
    localparam int unsigned ECC_CW_W   = ECC_DATA_W + 1;

    typedef struct packed {
        logic                  parity;
        logic [ECC_DATA_W-1:0] data;
    } ecc_cw_t;

    function automatic logic sed_parity(input logic [ECC_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ecc_sed_err_stats.sv
// Sticky error flag and saturating error counter; a clear never swallows a same-cycle error.
module ecc_sed_err_stats #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_evt,
    input  logic             err_clr,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (err_clr) begin
            sticky_d = err_evt;
            count_d  = err_evt ? CNT_W'(1) : '0;
        end else if (err_evt) begin
            sticky_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign err_sticky = sticky_q;
    assign err_count  = count_q;

endmodule

// File: rtl/ecc_sed_decoder.sv
// SED parity check with one registered valid/ready stage and error statistics.
// Optional ECC_SED_DROP_ERR_EN: erroneous words are counted but not forwarded.
module ecc_sed_decoder
    import ecc_sed_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W:0]   enc_codeword,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_err,
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    logic              syn;
    logic              accept;
    logic              xfer;
    logic              load;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    if (DATA_W == ECC_DATA_W) begin : g_pkg_syn
        ecc_cw_t cw;
        assign cw  = ecc_cw_t'(enc_codeword);
        assign syn = cw.parity ^ sed_parity(cw.data);
    end else begin : g_gen_syn
        assign syn = ^enc_codeword;
    end

    // Ready depends only on the output register and downstream, never on enc_valid.
    assign enc_ready = !valid_q || dec_ready;
    assign accept    = enc_valid && enc_ready;
    assign xfer      = valid_q && dec_ready;

`ifdef ECC_SED_DROP_ERR_EN
    assign load    = accept && !syn;
    assign dec_err = 1'b0;
`else
    logic err_q;

    assign load = accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (load) begin
            err_q <= syn;
        end
    end

    assign dec_err = err_q;
`endif

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = enc_codeword[DATA_W-1:0];
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dec_valid = valid_q;
    assign dec_data  = data_q;

    ecc_sed_err_stats #(
        .CNT_W (CNT_W)
    ) u_err_stats (
        .clk        (clk),
        .rst        (rst),
        .err_evt    (accept && syn),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Directed bench for ecc_sed_decoder with a scoreboard of expected output words.
module tb_ecc_sed_decoder;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 4;
`ifdef ECC_SED_DROP_ERR_EN
    localparam bit DROP = 1'b1;
    localparam logic [12:0] STALL_W0 = 13'h0005;
    localparam logic [12:0] STALL_W1 = 13'h1007;
`else
    localparam bit DROP = 1'b0;
    localparam logic [12:0] STALL_W0 = 13'h1003;
    localparam logic [12:0] STALL_W1 = 13'h0003;
`endif

    logic              clk;
    logic              rst;
    logic              enc_valid;
    logic              enc_ready;
    logic [DATA_W:0]   enc_codeword;
    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;
    logic              err_clr;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_count;

    typedef struct packed {
        logic [11:0] data;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] cyc      = 0;
    bit          tight    = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    bit          exp_sticky = 1'b0;

    ecc_sed_decoder #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_ready    (enc_ready),
        .enc_codeword (enc_codeword),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data),
        .dec_err      (dec_err),
        .err_clr      (err_clr),
        .err_sticky   (err_sticky),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_count"}, 32'(err_count), 32'(exp_cnt));
        chk({tag, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
    endtask

    // Output monitor: sampled mid-cycle, ahead of the edge where the transfer happens.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst && dec_valid && dec_ready) begin
            if (q.size() == 0) begin
                chk("spurious_word", 32'(dec_valid), 32'(0));
            end else begin
                e = q.pop_front();
                chk("dec_data", 32'(dec_data), 32'(e.data));
                chk("dec_err", 32'(dec_err), 32'(e.err));
                if (tight) chk("latency", cyc - e.cyc, 32'd1);
            end
        end
    end

    task automatic send(input logic [12:0] cw, input bit clr);
        int n;
        bit s;
        n = 0;
        s = ^cw;
        enc_valid    = 1'b1;
        enc_codeword = cw;
        err_clr      = clr;
        #1;
        while (!enc_ready && n < 50) begin
            if (clr) begin
                exp_cnt    = '0;
                exp_sticky = 1'b0;
            end
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", 32'(enc_ready), 32'd1);
        if (enc_ready) begin
            if (clr) begin
                exp_cnt    = s ? CNT_W'(1) : '0;
                exp_sticky = s;
            end else if (s) begin
                if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
                exp_sticky = 1'b1;
            end
            if (!(DROP && s)) q.push_back('{data: cw[11:0], err: (DROP ? 1'b0 : s), cyc: cyc});
        end
        @(negedge clk);
        enc_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        enc_valid    = 1'b0;
        enc_codeword = '0;
        dec_ready    = 1'b1;
        err_clr      = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_enc_ready", 32'(enc_ready), 32'd1);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_data", 32'(dec_data), 32'd0);
        chk("rst_dec_err", 32'(dec_err), 32'd0);
        chk_stats("rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Clean back-to-back stream, each word one cycle after its accept.
        tight = 1'b1;
        send(13'h0FFF, 1'b0);
        send(13'h1001, 1'b0);
        send(13'h0000, 1'b0);
        repeat (2) @(negedge clk);
        tight = 1'b0;
        #1 chk_stats("clean");

        // Single-bit errors.
        send(13'h0001, 1'b0);
        send(13'h1FFF, 1'b0);
        repeat (2) @(negedge clk);
        #1 chk_stats("single_err");
        chk("single_err_count_abs", 32'(err_count), 32'd2);

        // Backpressure: first word held, second word refused while stalled.
        dec_ready = 1'b0;
        send(STALL_W0, 1'b0);
        enc_valid    = 1'b1;
        enc_codeword = STALL_W1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_enc_ready", 32'(enc_ready), 32'd0);
            chk("stall_dec_valid", 32'(dec_valid), 32'd1);
            chk("stall_dec_data", 32'(dec_data), 32'(STALL_W0[11:0]));
            @(negedge clk);
        end
        dec_ready = 1'b1;
        send(STALL_W1, 1'b0);
        repeat (3) @(negedge clk);
        chk("stall_drained", q.size(), 32'd0);

        // Clear in the same cycle as an erroneous accept keeps the event.
        send(13'h1000, 1'b1);
        #1 chk_stats("clr_with_err");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr    = 1'b0;
        exp_cnt    = '0;
        exp_sticky = 1'b0;
        #1 chk_stats("clr_alone");

        // Saturation at all-ones.
        for (int i = 0; i < 20; i++) send(13'h0001, 1'b0);
        repeat (2) @(negedge clk);
        #1 chk_stats("saturate");
        chk("saturate_abs", 32'(err_count), 32'hF);

        // Asynchronous reset while a word is stalled.
        dec_ready = 1'b0;
        send(13'h0001, 1'b0);
        #1 chk("pre_rst_dec_valid", 32'(dec_valid), 32'(!DROP));
        #1 rst = 1'b0;
        #1;
        q.delete();
        exp_cnt    = '0;
        exp_sticky = 1'b0;
        chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
        chk("midrst_enc_ready", 32'(enc_ready), 32'd1);
        chk_stats("midrst");
        @(negedge clk);
        rst       = 1'b1;
        dec_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("no_replay", 32'(dec_valid), 32'd0);
        chk("final_queue", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
